// File: rtl/neuron_mac_pkg.sv
// Shared types, default widths and saturation limits for the neuron MAC engine.
// Optional build macro used by the engine: NEURON_MAC_RELU_EN.
package neuron_mac_pkg;

  localparam int DEF_N_INPUTS = 785;
  localparam int DEF_WGT_W    = 19;
  localparam int DEF_PIX_W    = 10;
  localparam int DEF_ACC_W    = 32;
  localparam int LIM_W        = 64;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCUM,
    ST_DRAIN,
    ST_DONE
  } state_t;

  function automatic logic [LIM_W-1:0] acc_max(input int w);
    return (LIM_W'(1) << (w - 1)) - LIM_W'(1);
  endfunction

  // Low w bits of the complement give 1000...0, the most negative value.
  function automatic logic [LIM_W-1:0] acc_min(input int w);
    return ~acc_max(w);
  endfunction

endpackage

// File: rtl/neuron_mac_if.sv
// Handshake bundle between a pixel/weight source, result sink and the engine.
// Build macro NEURON_MAC_RELU_EN affects only the engine, not this bundle.
interface neuron_mac_if
  import neuron_mac_pkg::*;
#(
  parameter int WGT_W = DEF_WGT_W,
  parameter int PIX_W = DEF_PIX_W,
  parameter int ACC_W = DEF_ACC_W
) ();

  logic             start;
  logic             in_valid;
  logic             in_ready;
  logic [WGT_W-1:0] in_wgt;
  logic [PIX_W-1:0] in_pix;
  logic             res_valid;
  logic             res_ready;
  logic [ACC_W-1:0] res_data;
  logic             res_sat;
  logic             busy;

  modport master (
    output start, in_valid, in_wgt, in_pix, res_ready,
    input  in_ready, res_valid, res_data, res_sat, busy
  );

  modport slave (
    input  start, in_valid, in_wgt, in_pix, res_ready,
    output in_ready, res_valid, res_data, res_sat, busy
  );

endinterface

// File: rtl/neuron_mac_sat_add.sv
// Signed adder clamping to the ACC_W range, flagging any clamp.
// Build macro NEURON_MAC_RELU_EN has no effect here.
module neuron_mac_sat_add
  import neuron_mac_pkg::*;
#(
  parameter int ACC_W = DEF_ACC_W
) (
  input  logic signed [ACC_W-1:0] i_a,
  input  logic signed [ACC_W-1:0] i_b,
  output logic signed [ACC_W-1:0] o_sum,
  output logic                    o_ovf
);

  localparam logic signed [ACC_W-1:0] MAX = ACC_W'(acc_max(ACC_W));
  localparam logic signed [ACC_W-1:0] MIN = ACC_W'(acc_min(ACC_W));

  logic signed [ACC_W-1:0] w_raw;
  logic                    w_pos_ovf;
  logic                    w_neg_ovf;

  assign w_raw = i_a + i_b;

  // Overflow only when both operands share a sign the raw sum lost.
  assign w_pos_ovf = !i_a[ACC_W-1] && !i_b[ACC_W-1] && w_raw[ACC_W-1];
  assign w_neg_ovf = i_a[ACC_W-1] && i_b[ACC_W-1] && !w_raw[ACC_W-1];

  always_comb begin
    o_sum = w_raw;
    unique case (1'b1)
      w_pos_ovf: o_sum = MAX;
      w_neg_ovf: o_sum = MIN;
      default:   o_sum = w_raw;
    endcase
  end

  assign o_ovf = w_pos_ovf || w_neg_ovf;

endmodule

// File: rtl/neuron_mac_engine.sv
// Two-stage multiply/saturating-accumulate engine for one neuron dot product.
// Define NEURON_MAC_RELU_EN to present negative final sums as zero.
module neuron_mac_engine
  import neuron_mac_pkg::*;
#(
  parameter int N_INPUTS = DEF_N_INPUTS,
  parameter int WGT_W    = DEF_WGT_W,
  parameter int PIX_W    = DEF_PIX_W,
  parameter int ACC_W    = DEF_ACC_W
) (
  input  logic        clk,
  input  logic        rst,
  neuron_mac_if.slave bus
);

  localparam int PRD_W = WGT_W + PIX_W + 1;
  localparam int CNT_W = $clog2(N_INPUTS + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N_INPUTS - 1);

  state_t                  r_state;
  state_t                  w_next;
  logic [CNT_W-1:0]        r_cnt;
  logic                    r_drain;
  logic                    r_pv;
  logic                    r_sat;
  logic signed [ACC_W-1:0] r_prod;
  logic signed [ACC_W-1:0] r_acc;
  logic signed [ACC_W-1:0] w_sum;
  logic signed [PRD_W-1:0] w_prod;
  logic                    w_beat;
  logic                    w_last;
  logic                    w_clear;
  logic                    w_ovf;

  assign w_beat = bus.in_valid && (r_state == ST_ACCUM);
  assign w_last = w_beat && (r_cnt == LAST);

  // Pixel is zero-extended so it multiplies as a non-negative value.
  assign w_prod = PRD_W'($signed(bus.in_wgt))
                * PRD_W'($signed({1'b0, bus.in_pix}));

  neuron_mac_sat_add #(
    .ACC_W (ACC_W)
  ) u_sat_add (
    .i_a   (r_acc),
    .i_b   (r_prod),
    .o_sum (w_sum),
    .o_ovf (w_ovf)
  );

  always_comb begin
    w_next  = r_state;
    w_clear = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (bus.start) begin
          w_next  = ST_ACCUM;
          w_clear = 1'b1;
        end
      end
      ST_ACCUM: begin
        if (w_last) w_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (r_drain) w_next = ST_DONE;
      end
      ST_DONE: begin
        if (bus.res_ready) begin
          w_next  = bus.start ? ST_ACCUM : ST_IDLE;
          w_clear = bus.start;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_drain <= 1'b0;
      r_pv    <= 1'b0;
      r_prod  <= '0;
      r_acc   <= '0;
      r_sat   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_drain <= (r_state == ST_DRAIN) && !r_drain;
      r_pv    <= w_beat;
      if (w_beat) r_prod <= ACC_W'(w_prod);
      if (w_clear) begin
        r_cnt <= '0;
        r_acc <= '0;
        r_sat <= 1'b0;
      end else begin
        if (w_beat) r_cnt <= r_cnt + CNT_W'(1);
        if (r_pv) begin
          r_acc <= w_sum;
          r_sat <= r_sat || w_ovf;
        end
      end
    end
  end

  assign bus.in_ready  = (r_state == ST_ACCUM);
  assign bus.res_valid = (r_state == ST_DONE);
  assign bus.busy      = (r_state != ST_IDLE);
  assign bus.res_sat   = r_sat;

`ifdef NEURON_MAC_RELU_EN
  assign bus.res_data = r_acc[ACC_W-1] ? '0 : r_acc;
`else
  assign bus.res_data = r_acc;
`endif

endmodule

// File: tb/tb_neuron_mac_engine.sv
// Scoreboard bench for neuron_mac_engine: a 4-input instance and a default one.
// Expectations follow NEURON_MAC_RELU_EN when it is defined.
module tb_neuron_mac_engine;
  import neuron_mac_pkg::*;

  localparam int N4 = 4;
  localparam int WW = DEF_WGT_W;
  localparam int PW = DEF_PIX_W;
  localparam int AW = DEF_ACC_W;

  typedef struct {
    longint data;
    bit     sat;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  neuron_mac_if #(.WGT_W(WW), .PIX_W(PW), .ACC_W(AW)) if4 ();
  neuron_mac_if #(.WGT_W(WW), .PIX_W(PW), .ACC_W(AW)) ifd ();

  neuron_mac_engine #(
    .N_INPUTS (N4),
    .WGT_W    (WW),
    .PIX_W    (PW),
    .ACC_W    (AW)
  ) u_dut4 (
    .clk (clk),
    .rst (rst),
    .bus (if4)
  );

  neuron_mac_engine u_dutd (
    .clk (clk),
    .rst (rst),
    .bus (ifd)
  );

  exp_t q4[$];
  exp_t qd[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic chk(input string tag, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic exp_t model(input int w[$], input int p[$]);
    longint acc = 0;
    longint mx;
    longint mn;
    exp_t   e;
    mx    = (64'sd1 <<< (AW - 1)) - 64'sd1;
    mn    = -(64'sd1 <<< (AW - 1));
    e.sat = 1'b0;
    foreach (w[i]) begin
      acc += longint'(w[i]) * longint'(p[i]);
      if (acc > mx) begin
        acc   = mx;
        e.sat = 1'b1;
      end else if (acc < mn) begin
        acc   = mn;
        e.sat = 1'b1;
      end
    end
`ifdef NEURON_MAC_RELU_EN
    if (acc < 0) acc = 0;
`endif
    e.data = acc;
    return e;
  endfunction

  // Result monitor for the 4-input engine: hold stability and scoreboard.
  initial begin
    exp_t        e;
    logic [AW:0] held;
    bit          held_v;
    held_v = 1'b0;
    held   = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        held_v = 1'b0;
      end else if (if4.res_valid) begin
        if (held_v)
          chk("hold_stable", {if4.res_sat, if4.res_data}, held);
        else begin
          held   = {if4.res_sat, if4.res_data};
          held_v = 1'b1;
        end
        if (if4.res_ready) begin
          if (q4.size() == 0) chk("unexpected_result", 1, 0);
          else begin
            e = q4.pop_front();
            chk("res_data", $signed(if4.res_data), e.data);
            chk("res_sat", if4.res_sat, e.sat);
          end
          held_v = 1'b0;
        end
      end
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && ifd.res_valid && ifd.res_ready) begin
        if (qd.size() == 0) chk("dflt_unexpected", 1, 0);
        else begin
          e = qd.pop_front();
          chk("dflt_data", $signed(ifd.res_data), e.data);
          chk("dflt_sat", ifd.res_sat, e.sat);
        end
      end
    end
  end

  initial begin
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog: time limit reached, checks=%0d", n_checks);
    $fatal(1, "watchdog expired");
  end

  task automatic start4();
    if4.start = 1'b1;
    @(posedge clk); #1;
    if4.start = 1'b0;
  endtask

  task automatic feed4(input int w[$], input int p[$], input int n,
                       input bit gaps, input int start_at);
    int k = 0;
    int guard = 0;
    while (k < n && guard < 500) begin
      guard++;
      if (gaps && $urandom_range(0, 2) == 0) begin
        if4.in_valid = 1'b0;
        if4.in_wgt   = WW'(-1);
        if4.in_pix   = PW'(1023);
      end else begin
        if4.in_valid = 1'b1;
        if4.in_wgt   = WW'(w[k]);
        if4.in_pix   = PW'(p[k]);
      end
      if4.start = (k == start_at);
      @(negedge clk);
      if (if4.in_valid && if4.in_ready) k++;
      @(posedge clk); #1;
    end
    if4.in_valid = 1'b0;
    if4.start    = 1'b0;
    if (k < n) chk("feed_timeout", k, n);
  endtask

  task automatic wait_res(input string tag);
    int lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!if4.res_valid && lat < 20);
    chk(tag, lat, 3);
    @(posedge clk); #1;
  endtask

  initial begin
    int w[$];
    int p[$];
    int wd[$];
    int pd[$];
    int k;
    int guard;

    if4.start = 1'b0; if4.in_valid = 1'b0; if4.in_wgt = '0;
    if4.in_pix = '0;  if4.res_ready = 1'b1;
    ifd.start = 1'b0; ifd.in_valid = 1'b0; ifd.in_wgt = '0;
    ifd.in_pix = '0;  ifd.res_ready = 1'b1;

    repeat (3) @(negedge clk);
    chk("rst_in_ready", if4.in_ready, 0);
    chk("rst_res_valid", if4.res_valid, 0);
    chk("rst_res_data", if4.res_data, 0);
    chk("rst_res_sat", if4.res_sat, 0);
    chk("rst_busy", if4.busy, 0);
    chk("rst_dflt_busy", ifd.busy, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    w = '{1, 2, 3, 4}; p = '{10, 10, 10, 10};
    q4.push_back(model(w, p));
    start4();
    feed4(w, p, 4, 1'b0, -1);
    wait_res("lat_pos");

    w = '{-5, -5, -5, -5}; p = '{10, 10, 10, 10};
    q4.push_back(model(w, p));
    start4();
    feed4(w, p, 4, 1'b0, -1);
    wait_res("lat_neg");

    if4.res_ready = 1'b0;
    w = '{-300, 1200, 77, -9}; p = '{1023, 511, 3, 0};
    q4.push_back(model(w, p));
    start4();
    feed4(w, p, 4, 1'b1, -1);
    wait_res("lat_gaps");
    repeat (10) begin
      @(posedge clk); #1;
    end
    chk("held_valid", if4.res_valid, 1);
    if4.res_ready = 1'b1;
    @(posedge clk); #1;
    chk("released_valid", if4.res_valid, 0);
    chk("one_consumed", q4.size(), 0);

    w = '{9, 9}; p = '{9, 9};
    start4();
    feed4(w, p, 2, 1'b0, -1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_in_ready", if4.in_ready, 0);
    chk("abort_res_valid", if4.res_valid, 0);
    chk("abort_busy", if4.busy, 0);
    chk("abort_res_data", if4.res_data, 0);
    repeat (8) begin
      @(posedge clk); #1;
    end
    w = '{2, 2, 2, 2}; p = '{3, 3, 3, 3};
    q4.push_back(model(w, p));
    start4();
    feed4(w, p, 4, 1'b0, -1);
    wait_res("lat_after_rst");

    if4.res_ready = 1'b0;
    w = '{7, -3, 5, 1}; p = '{2, 4, 6, 8};
    q4.push_back(model(w, p));
    start4();
    feed4(w, p, 4, 1'b0, 2);
    wait_res("lat_mid_start");
    w = '{100, -50, 25, 3}; p = '{1000, 1023, 0, 512};
    q4.push_back(model(w, p));
    if4.start     = 1'b1;
    if4.res_ready = 1'b1;
    @(posedge clk); #1;
    if4.start = 1'b0;
    chk("b2b_in_ready", if4.in_ready, 1);
    chk("b2b_busy", if4.busy, 1);
    feed4(w, p, 4, 1'b0, -1);
    wait_res("lat_b2b");

    for (int i = 0; i < DEF_N_INPUTS; i++) begin
      wd.push_back(262143);
      pd.push_back(1023);
    end
    qd.push_back(model(wd, pd));
    ifd.start = 1'b1;
    @(posedge clk); #1;
    ifd.start    = 1'b0;
    ifd.in_valid = 1'b1;
    ifd.in_wgt   = WW'(262143);
    ifd.in_pix   = PW'(1023);
    k = 0;
    guard = 0;
    while (k < DEF_N_INPUTS && guard < 2000) begin
      guard++;
      @(negedge clk);
      if (ifd.in_ready) k++;
      @(posedge clk); #1;
    end
    ifd.in_valid = 1'b0;
    chk("dflt_beats", k, DEF_N_INPUTS);
    guard = 0;
    while (qd.size() != 0 && guard < 20) begin
      guard++;
      @(posedge clk); #1;
    end
    chk("dflt_consumed", qd.size(), 0);

    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("sb_empty", q4.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/neuron_mac_engine.md
NEURON_MAC_ENGINE -- requirements
Module: neuron_mac_engine

Interface
REQ-001 Parameter N_INPUTS, default 785, number of (weight, pixel) pairs per dot product; SHALL be at least 1.
REQ-002 Parameter WGT_W, default 19, weight width, signed two's complement.
REQ-003 Parameter PIX_W, default 10, pixel width, unsigned.
REQ-004 Parameter ACC_W, default 32, accumulator/result width, signed; SHALL be at least WGT_W+PIX_W+1.
REQ-005 clk  input  1  clock; all state changes on rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 start  input  1  one-cycle request to begin a new dot product.
REQ-008 in_valid  input  1  in_wgt/in_pix carry a valid pair.
REQ-009 in_ready  output  1  engine accepts a pair this cycle.
REQ-010 in_wgt  input  WGT_W  weight operand.
REQ-011 in_pix  input  PIX_W  pixel operand.
REQ-012 res_valid  output  1  res_data/res_sat hold the final result.
REQ-013 res_ready  input  1  consumer accepts the result.
REQ-014 res_data  output  ACC_W  final dot-product sum.
REQ-015 res_sat  output  1  saturation occurred during this computation.
REQ-016 busy  output  1  high in every state except IDLE.

Function
REQ-017 FSM states SHALL be IDLE, ACCUM, DRAIN, DONE.
REQ-018 IDLE->ACCUM on start; the same edge clears the accumulator, beat counter and res_sat to 0.
REQ-019 in_ready SHALL be 1 only in ACCUM; a beat is a cycle with in_valid&&in_ready; gaps in in_valid are allowed.
REQ-020 Stage 1 registers product = signed(in_wgt) x zero-extended(in_pix), width WGT_W+PIX_W+1, sign-extended to ACC_W.
REQ-021 Stage 2 adds the registered product to the accumulator with saturation to [-2^(ACC_W-1), 2^(ACC_W-1)-1]; any clamp sets res_sat, which stays set until the next start.
REQ-022 The N_INPUTS-th beat moves ACCUM->DRAIN; DRAIN lasts exactly 2 cycles, then DONE.
REQ-023 With the final beat accepted in cycle T, res_valid SHALL first be 1 in cycle T+3.
REQ-024 In DONE, res_valid=1 and res_data/res_sat SHALL stay stable until res_ready=1; that edge leaves DONE.
REQ-025 In DONE with res_ready && start in the same cycle, the FSM goes directly to ACCUM with cleared state (back-to-back operation); with res_ready alone it goes to IDLE.
REQ-026 start outside IDLE/DONE SHALL be ignored and has no effect on the running sum.
REQ-027 Pairs presented while in_ready=0 SHALL be ignored.

Reset
REQ-028 rst SHALL force IDLE, in_ready=0, res_valid=0, res_data=0, res_sat=0, busy=0, and clear the counter, pipeline register and accumulator.
REQ-029 rst in any state, including mid-ACCUM or DONE, SHALL discard the partial or pending result; no res_valid follows.

Configuration
REQ-030 Macro NEURON_MAC_RELU_EN defined: a negative final sum is presented as res_data=0; res_sat is unaffected.
REQ-031 Macro NEURON_MAC_RELU_EN undefined: res_data is the signed saturated sum unchanged.

Structure
REQ-032 Package neuron_mac_pkg SHALL hold the FSM state enum, default width constants, and the ACC_W min/max saturation-limit functions.
REQ-033 Saturating addition SHALL be a sub-module neuron_mac_sat_add (ACC_W parameter; outputs sum and overflow flag).

Verification
REQ-034 N_INPUTS=4: weights {1,2,3,4}, pixels all 10 -> res_data=100, res_sat=0, res_valid in cycle T+3.
REQ-035 N_INPUTS=4: weights {-5,-5,-5,-5}, pixels {10,10,10,10} -> res_data=-200 without NEURON_MAC_RELU_EN, 0 with it.
REQ-036 Defaults: 785 beats of weight 262143, pixel 1023 -> res_data=2147483647, res_sat=1.
REQ-037 N_INPUTS=4 with random in_valid gaps and res_ready held low 10 cycles -> correct sum, res_data stable throughout, one result consumed.
REQ-038 rst after 2 of 4 beats -> in_ready=0 and no res_valid; a new start with 4 beats of weight 2, pixel 3 -> res_data=24.
REQ-039 start during ACCUM -> ignored, sum unaffected; start together with res_ready in DONE -> next computation begins with no IDLE cycle and yields its correct sum.
